// File: rtl/frame_sync.sv
// frame_sync: confirms that the 110101 detector's one-cycle `hit` recurs
// every FRAME_LEN cycles. After VERIFY_N consecutive on-time hits it declares
// lock. It then flywheels a frame-boundary strobe through up to MISS_N-1
// consecutive missed slots, and drops back to HUNT on the MISS_N-th miss.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   clr       synchronous clear (back to HUNT, statistics zeroed)
//   hit       pattern-detector strobe
//   locked    high while in LOCK (registered)
//   sync      one-cycle frame-boundary strobe (registered)
//   state     HUNT=00, VERIFY=01, LOCK=10
//   frame_cnt saturating count of sync pulses
//   miss_cnt  saturating count of missed slots while locked
module frame_sync #(
    parameter int FRAME_LEN = 16,
    parameter int VERIFY_N  = 3,
    parameter int MISS_N    = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hit,
    output logic             locked,
    output logic             sync,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int POS_W  = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam int GOOD_W = $clog2(VERIFY_N + 1);
    localparam int MISS_W = (MISS_N > 1) ? $clog2(MISS_N + 1) : 1;

    localparam logic [1:0] HUNT   = 2'b00;
    localparam logic [1:0] VERIFY = 2'b01;
    localparam logic [1:0] LOCK   = 2'b10;

    // Compare against "last value before the target" so that no
    // width-extended increment is needed in the comparison.
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(VERIFY_N - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [POS_W-1:0]  pos;
    logic [GOOD_W-1:0] good;
    logic [MISS_W-1:0] miss;
    logic              slot;

    // The expected slot is FRAME_LEN cycles after the reference hit.
    assign slot = (pos == POS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            locked    <= 1'b0;
            sync      <= 1'b0;
            frame_cnt <= '0;
            miss_cnt  <= '0;
            pos       <= '0;
            good      <= '0;
            miss      <= '0;
        end else if (clr) begin
            // A hit in the same cycle as clr is discarded.
            state     <= HUNT;
            locked    <= 1'b0;
            sync      <= 1'b0;
            frame_cnt <= '0;
            miss_cnt  <= '0;
            pos       <= '0;
            good      <= '0;
            miss      <= '0;
        end else begin
            sync <= 1'b0;
            pos  <= slot ? '0 : pos + POS_W'(1);

            case (state)
                HUNT: begin
                    if (hit) begin
                        state <= VERIFY;
                        good  <= GOOD_W'(1);
                        pos   <= '0;
                    end
                end

                VERIFY: begin
                    if (slot) begin
                        if (hit) begin
                            if (good == GOOD_LAST) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                                sync   <= 1'b1;
                                miss   <= '0;
                                if (frame_cnt != CNT_MAX)
                                    frame_cnt <= frame_cnt + CNT_W'(1);
                            end else begin
                                good <= good + GOOD_W'(1);
                            end
                        end else begin
                            state <= HUNT;
                            good  <= '0;
                        end
                    end else if (hit) begin
                        // An off-slot hit becomes the new reference.
                        good <= GOOD_W'(1);
                        pos  <= '0;
                    end
                end

                LOCK: begin
                    // Off-slot hits are ignored, so the phase keeps running.
                    if (slot) begin
                        if (miss_cnt != CNT_MAX)
                            miss_cnt <= miss_cnt + (hit ? CNT_W'(0) : CNT_W'(1));
                        if (hit || miss != MISS_LAST) begin
                            // On-time hit, or a miss that the flywheel covers.
                            miss <= hit ? '0 : miss + MISS_W'(1);
                            sync <= 1'b1;
                            if (frame_cnt != CNT_MAX)
                                frame_cnt <= frame_cnt + CNT_W'(1);
                        end else begin
                            state  <= HUNT;
                            locked <= 1'b0;
                            miss   <= '0;
                            good   <= '0;
                        end
                    end
                end

                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sync.sv
// Directed bench for frame_sync with FRAME_LEN=16, VERIFY_N=3, MISS_N=2.
// Cycle numbers count from reset release. Inputs for cycle c are applied
// before the edge that ends cycle c, and outputs are sampled 1 ns after
// that edge, which shows the state of cycle c+1.
module tb_frame_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       hit;
    logic       locked;
    logic       sync;
    logic [1:0] state;
    logic [7:0] frame_cnt;
    logic [7:0] miss_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int hits[$];
    int syncs[$];

    frame_sync #(.FRAME_LEN(16), .VERIFY_N(3), .MISS_N(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .hit       (hit),
        .locked    (locked),
        .sync      (sync),
        .state     (state),
        .frame_cnt (frame_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit hit_at(input int c);
        foreach (hits[i]) if (hits[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (sync) begin
            syncs.push_back(cyc);
            chk("sync_only_in_lock", 32'(locked), 1);
        end
    endtask

    // Advance until the outputs of cycle t are visible.
    task automatic run_to(input int t);
        while (cyc < t) begin
            hit = hit_at(cyc);
            step();
        end
        hit = 1'b0;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        cyc   = 0;
        hits  = {};
        syncs = {};
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        hit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",  32'(state), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_sync",   32'(sync), 0);
        chk("rst_frame",  32'(frame_cnt), 0);
        chk("rst_miss",   32'(miss_cnt), 0);
        release_rst();

        // Lock, steady lock, flywheel, lock loss
        hits = {10, 26, 42, 58, 66, 74, 106};
        run_to(1);
        chk("hunt_after_release", 32'(state), 0);
        run_to(42);
        chk("verify_before_lock", 32'(state), 1);
        chk("no_sync_before_43",  syncs.size(), 0);
        run_to(43);
        chk("lock_locked", 32'(locked), 1);
        chk("lock_sync",   32'(sync), 1);
        chk("lock_frame",  32'(frame_cnt), 1);
        chk("lock_state",  32'(state), 2);
        run_to(44);
        chk("sync_one_cycle", 32'(sync), 0);
        run_to(67);
        chk("offslot_no_sync", 32'(sync), 0);
        chk("syncs_by_67",     syncs.size(), 2);
        run_to(75);
        chk("steady_sync",  32'(sync), 1);
        chk("steady_frame", 32'(frame_cnt), 3);
        chk("steady_miss",  32'(miss_cnt), 0);
        run_to(91);
        chk("fly_sync",   32'(sync), 1);
        chk("fly_miss",   32'(miss_cnt), 1);
        chk("fly_locked", 32'(locked), 1);
        run_to(107);
        chk("fly_resync", 32'(sync), 1);
        chk("fly_frame",  32'(frame_cnt), 5);
        chk("fly_miss2",  32'(miss_cnt), 1);
        run_to(123);
        chk("loss_fly_sync", 32'(sync), 1);
        chk("loss_frame123", 32'(frame_cnt), 6);
        chk("loss_miss123",  32'(miss_cnt), 2);
        run_to(139);
        chk("loss_locked", 32'(locked), 0);
        chk("loss_state",  32'(state), 0);
        chk("loss_sync",   32'(sync), 0);
        chk("loss_miss",   32'(miss_cnt), 3);
        chk("loss_frame",  32'(frame_cnt), 6);
        chk("loss_nsyncs", syncs.size(), 6);
        chk("loss_last_sync", syncs[syncs.size()-1], 123);

        // Verify restart on an off-slot hit
        rst = 1'b1;
        release_rst();
        hits = {10, 20, 36, 52};
        run_to(27);
        chk("restart_still_verify", 32'(state), 1);
        run_to(52);
        chk("restart_not_locked", 32'(locked), 0);
        run_to(53);
        chk("restart_locked", 32'(locked), 1);
        chk("restart_sync",   32'(sync), 1);

        // Asynchronous reset mid-LOCK, sampled before any edge
        #1;
        rst = 1'b1;
        #1;
        chk("async_locked", 32'(locked), 0);
        chk("async_sync",   32'(sync), 0);
        chk("async_frame",  32'(frame_cnt), 0);
        chk("async_state",  32'(state), 0);
        release_rst();

        // Missed verify slot, then clr together with hit
        hits = {10, 30, 46, 62};
        run_to(26);
        chk("miss_verify_26", 32'(state), 1);
        run_to(27);
        chk("miss_hunt_27", 32'(state), 0);
        run_to(31);
        chk("reverify_31", 32'(state), 1);
        run_to(63);
        chk("relock_63", 32'(locked), 1);
        chk("relock_frame", 32'(frame_cnt), 1);
        run_to(70);
        clr = 1'b1;
        hit = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_state",  32'(state), 0);
        chk("clr_locked", 32'(locked), 0);
        chk("clr_frame",  32'(frame_cnt), 0);
        chk("clr_miss",   32'(miss_cnt), 0);
        step();
        hit = 1'b0;
        chk("hit_after_clr", 32'(state), 1);

        // Frame counter saturation: reference at 71, lock shows at 104
        for (int k = 1; k <= 270; k++) hits.push_back(71 + 16*k);
        run_to(104);
        chk("sat_lock", 32'(locked), 1);
        run_to(104 + 16*253);
        chk("sat_frame_254", 32'(frame_cnt), 254);
        run_to(104 + 16*254);
        chk("sat_frame_255", 32'(frame_cnt), 255);
        run_to(104 + 16*268);
        chk("sat_frame_hold", 32'(frame_cnt), 255);
        chk("sat_sync",       32'(sync), 1);
        chk("sat_miss",       32'(miss_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_sync.md
# frame_sync

Frame synchronizer that sits directly downstream of the 110101 pattern detector and consumes its one-cycle `hit` output. It confirms that the sync pattern recurs at a fixed frame spacing, declares lock after a programmable number of consecutive on-time hits, and holds lock through isolated misses. While locked it flywheels a frame-boundary strobe. It also keeps saturating frame and miss statistics for the control side.

## Interface
- `FRAME_LEN`, 16: hit-to-hit spacing in clock cycles. Must be ≥ 2.
- `VERIFY_N`, 3: consecutive on-time hits, counting the reference hit, needed to lock. Must be ≥ 2.
- `MISS_N`, 2: consecutive missed slots that drop lock. Must be ≥ 1.
- `CNT_W`, 8: width of the statistics counters.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset. Forces the reset state immediately.
- `clr`  in  1  synchronous clear: returns to HUNT and zeroes both counters.
- `hit`  in  1  detector output, one bit period per cycle; may be high on consecutive cycles.
- `locked`  out  1  registered; high while in LOCK.
- `sync`  out  1  registered one-cycle frame-boundary strobe.
- `state`  out  2  HUNT=00, VERIFY=01, LOCK=10.
- `frame_cnt`  out  CNT_W  count of `sync` pulses; saturates at all-ones.
- `miss_cnt`  out  CNT_W  count of missed slots in LOCK; saturates at all-ones.

## Operation
Internal registers:
- `pos`: phase counter, width clog2(FRAME_LEN).
- `good`: on-time hit count, 0..VERIFY_N.
- `miss`: consecutive-miss count, 0..MISS_N.

Phase rule:
- An accepted reference hit loads `pos`=0 at the next edge.
- Otherwise `pos` increments each cycle and wraps FRAME_LEN-1 → 0.
- The expected slot is the cycle with `pos`==FRAME_LEN-1, i.e. exactly FRAME_LEN cycles after the reference hit.

HUNT:
- `hit` → VERIFY, `good`=1, `pos`=0.
- Otherwise stay in HUNT; `pos` is don't-care.

VERIFY:
- Slot with `hit`: `good`+1. If the new value equals VERIFY_N → LOCK, with `sync`=1, `locked`=1 and `frame_cnt`+1 next cycle. Otherwise stay in VERIFY.
- Slot without `hit` → HUNT.
- Off-slot `hit`: restart from that hit (`good`=1, `pos`=0, stay in VERIFY).

LOCK:
- Slot with `hit`: `miss`=0, `sync`=1, `frame_cnt`+1.
- Slot without `hit`: `miss`+1 and `miss_cnt`+1.
  - If the new `miss` < MISS_N: flywheel `sync`=1 and `frame_cnt`+1.
  - If `miss` reaches MISS_N → HUNT: `locked`=0, no `sync` on that slot, `miss`=0.
- Off-slot hits are ignored; phase is unchanged.

Priority:
- `rst` > `clr` > everything else.
- `clr` together with `hit`: `clr` wins and the hit is discarded (state HUNT next cycle).
- Counters saturate and never wrap.
- `clr` does not affect the counting of a `hit` on the following cycle.

## Timing
- Reset values: `state`=HUNT, `locked`=0, `sync`=0, `frame_cnt`=0, `miss_cnt`=0, `pos`=0, `good`=0, `miss`=0.
- All outputs are registered. A slot evaluated in cycle t shows its `sync`, `locked`, `state` and counter updates in cycle t+1.
- `sync` is high for exactly one cycle per slot and is never high in HUNT or VERIFY.
- Minimum lock latency: (VERIFY_N-1)·FRAME_LEN+1 cycles after the reference hit.
- Lock loss appears MISS_N·FRAME_LEN+1 cycles after the last on-time hit.
- Asserting `rst` mid-frame clears everything with no edge needed.
- Deasserting `rst` gives HUNT at the first edge.

## Test plan
All scenarios use FRAME_LEN=16, VERIFY_N=3, MISS_N=2; cycle numbers are counted from reset release.
- Lock: hits at cycles 10, 26, 42 → cycle 43 shows `locked`=1, `sync`=1, `frame_cnt`=1, `state`=10; there is no `sync` before cycle 43.
- Steady lock: continue with hits at 58 and 74 → `sync` at 59 and 75, `frame_cnt`=3, `miss_cnt`=0; an extra hit at 66 produces no `sync` and no phase shift.
- Flywheel: omit the hit at 90, hit at 106 → `sync` at 91 and 107, `miss_cnt`=1, `locked` stays 1.
- Lock loss: then omit the hits at 122 and 138 → `sync` at 123 only; cycle 139 shows `locked`=0, `state`=00, `miss_cnt`=3; `frame_cnt` is unchanged from cycle 123 onward.
- Verify restart: from reset, hits at 10, 20, 36, 52 → phase re-references at 20, `locked` rises at cycle 53. Hits at 10, 30 → HUNT at cycle 27, then VERIFY at 31.
- Reset/clear: async `rst` mid-LOCK → `locked`, `sync` and counters are 0 before the next edge. Then `clr` and `hit` in the same cycle → `state`=HUNT next cycle and the counters stay 0.
